// File: rtl/frame_reader_pkg.sv
// Shared widths, default frame geometry and FSM encoding for the frame reader.
package frame_reader_pkg;

    localparam int PIXEL_W      = 18;
    localparam int ADDR_W       = 19;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int H_PIXELS_DEF = 640;
    localparam int V_PIXELS_DEF = 480;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FRAME_START = 2'd1,
        STREAM      = 2'd2,
        DRAIN       = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] last_addr(input int unsigned h, input int unsigned v);
        return ADDR_W'(h * v - 1);
    endfunction

endpackage

// File: rtl/frame_reader_if.sv
// Memory read port plus pixel stream of the frame reader; master is the reader itself.
interface frame_reader_if;
    import frame_reader_pkg::*;

    logic               start;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_re;
    logic [PIXEL_W-1:0] mem_data;
    logic               frame_flag;
    logic [PIXEL_W-1:0] pixel;
    logic               pixel_flag;
    logic [X_W-1:0]     pixel_x;
    logic [Y_W-1:0]     pixel_y;
    logic               pixel_ready;
    logic               busy;

    modport master (
        input  start, mem_data, pixel_ready,
        output mem_addr, mem_re, frame_flag, pixel, pixel_flag, pixel_x, pixel_y, busy
    );

    modport slave (
        output start, mem_data, pixel_ready,
        input  mem_addr, mem_re, frame_flag, pixel, pixel_flag, pixel_x, pixel_y, busy
    );

endinterface

// File: rtl/frame_reader_pixel_fifo.sv
// First-word-fall-through output buffer; DEPTH must be a power of two (>= 2).
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/frame_reader.sv
// Streams one frame from a fixed-latency memory into a credit-limited FWFT pixel buffer.
// States: IDLE wait start | FRAME_START flag, clear | STREAM issue reads | DRAIN empty pipe
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int unsigned H_PIXELS   = H_PIXELS_DEF,
    parameter int unsigned V_PIXELS   = V_PIXELS_DEF,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    frame_reader_if.master bus
);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = last_addr(H_PIXELS, V_PIXELS);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_PIXELS - 1);

    state_t             state_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [ADDR_W-1:0]  issue_addr_d;
    logic               mem_re_q;
    logic               frame_flag_q;
    logic               busy_q;
    logic               issue_d;
    logic [RD_LAT-1:0]  inflight_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [CR_W-1:0]    credit_d;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [OCC_W-1:0]   occ;
    logic [PIXEL_W-1:0] fifo_head;

    assign push = inflight_q[RD_LAT-1];
    assign pop  = ~fifo_empty & bus.pixel_ready;

    // Credit in use once this cycle's pop retires: buffered + being issued + in the latency pipe.
    always_comb begin
        credit_d = CR_W'(occ) + CR_W'(mem_re_q);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            credit_d = credit_d + CR_W'(inflight_q[i]);
        end
        credit_d = credit_d - CR_W'(pop);
    end

    assign issue_addr_d = (state_q == FRAME_START) ? '0 : rd_addr_q;
    assign issue_d      = ((state_q == FRAME_START) || (state_q == STREAM)) &&
                          (credit_d < CR_W'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            frame_flag_q <= 1'b0;
            busy_q       <= 1'b0;
            inflight_q   <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            mem_re_q      <= issue_d;
            frame_flag_q  <= 1'b0;
            inflight_q[0] <= mem_re_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                inflight_q[i] <= inflight_q[i-1];
            end

            if (issue_d) begin
                mem_addr_q <= issue_addr_d;
                rd_addr_q  <= issue_addr_d + ADDR_W'(1);
            end

            if (pop) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q      <= FRAME_START;
                        frame_flag_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                FRAME_START, STREAM: begin
                    if (state_q == FRAME_START) begin
                        x_q <= '0;
                        y_q <= '0;
                    end
                    state_q <= (issue_d && (issue_addr_d == ADDR_LAST)) ? DRAIN : STREAM;
                end
                DRAIN: begin
                    if (credit_d == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIXEL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .data_i  (bus.mem_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (occ)
    );

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.frame_flag = frame_flag_q;
    assign bus.busy       = busy_q;
    assign bus.pixel      = fifo_head;
    assign bus.pixel_flag = ~fifo_empty;
    assign bus.pixel_x    = x_q;
    assign bus.pixel_y    = y_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: scoreboard on a 16x8 frame plus a table-driven 4x2 frame.
module tb_frame_reader;
    import frame_reader_pkg::*;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int NPIX  = H * V;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int HS    = 4;
    localparam int VS    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_reader_if bus ();
    frame_reader_if bus_s ();

    frame_reader #(.H_PIXELS(H), .V_PIXELS(V), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    frame_reader #(.H_PIXELS(HS), .V_PIXELS(VS), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.master)
    );

    // Memory models: data = address, returned LAT cycles after the strobe; junk otherwise.
    logic              m1v = 1'b0, m2v = 1'b0, s1v = 1'b0, s2v = 1'b0;
    logic [ADDR_W-1:0] m1a = '0, m2a = '0, s1a = '0, s2a = '0;
    always @(posedge clk) begin
        m1v <= bus.mem_re;   m1a <= bus.mem_addr;   m2v <= m1v; m2a <= m1a;
        s1v <= bus_s.mem_re; s1a <= bus_s.mem_addr; s2v <= s1v; s2a <= s1a;
    end
    assign bus.mem_data   = m2v ? PIXEL_W'(m2a) : '1;
    assign bus_s.mem_data = s2v ? PIXEL_W'(s2a) : '1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and monitors for the main instance
    int issued = 0, accepted = 0, frame_flags = 0;
    int credit_viol = 0, stable_viol = 0, coincide = 0;
    int exp_addr = 0;
    int sbq[$];
    logic hold_prev = 1'b0;
    logic [PIXEL_W-1:0] p_pix;
    logic [X_W-1:0] p_x;
    logic [Y_W-1:0] p_y;

    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            issued    = 0;
            accepted  = 0;
            exp_addr  = 0;
            hold_prev = 1'b0;
        end else begin
            if (bus.frame_flag) begin
                frame_flags++;
                issued   = 0;
                accepted = 0;
                exp_addr = 0;
                if (bus.pixel_flag) coincide++;
            end
            if (hold_prev) begin
                if (!bus.pixel_flag || bus.pixel != p_pix || bus.pixel_x != p_x || bus.pixel_y != p_y)
                    stable_viol++;
            end
            if (bus.mem_re) begin
                check("mem_addr", int'(bus.mem_addr), exp_addr);
                sbq.push_back(int'(bus.mem_addr));
                exp_addr++;
                issued++;
            end
            if (issued - accepted > DEPTH) credit_viol++;
            if (bus.pixel_flag && bus.pixel_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_pixel", 1, 0);
                end else begin
                    int e;
                    e = sbq.pop_front();
                    check("pixel", int'(bus.pixel), e);
                    check("pixel_x", int'(bus.pixel_x), e % H);
                    check("pixel_y", int'(bus.pixel_y), e / H);
                end
                accepted++;
            end
            hold_prev = bus.pixel_flag && !bus.pixel_ready;
            p_pix = bus.pixel;
            p_x   = bus.pixel_x;
            p_y   = bus.pixel_y;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_mem_re"},     int'(bus.mem_re), 0);
        check({tag, "_mem_addr"},   int'(bus.mem_addr), 0);
        check({tag, "_frame_flag"}, int'(bus.frame_flag), 0);
        check({tag, "_pixel_flag"}, int'(bus.pixel_flag), 0);
        check({tag, "_pixel"},      int'(bus.pixel), 0);
        check({tag, "_pixel_x"},    int'(bus.pixel_x), 0);
        check({tag, "_pixel_y"},    int'(bus.pixel_y), 0);
        check({tag, "_busy"},       int'(bus.busy), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit, output int cyc);
        cyc = 0;
        while (bus.busy && cyc < limit) begin
            tick();
            cyc++;
        end
        check({tag, "_idle_in_time"}, int'(bus.busy), 0);
    endtask

    typedef struct {
        int stall;
        int x;
        int y;
        int pix;
    } vec_t;

    vec_t tbl[HS*VS];

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.pixel_ready = 1'b0;
        bus_s.start = 1'b0;
        bus_s.pixel_ready = 1'b0;

        repeat (3) tick();
        check_zero("in_reset");
        reset = 1'b0;
        tick();
        check_zero("after_reset");

        // Full frame, ready held high: latency, throughput, single frame_flag.
        bus.pixel_ready = 1'b1;
        frame_flags = 0;
        coincide = 0;
        pulse_start();
        check("frame_flag_pulse", int'(bus.frame_flag), 1);
        check("busy_after_start", int'(bus.busy), 1);
        cyc = 0;
        while (!bus.pixel_flag && cyc < 20) begin
            tick();
            cyc++;
        end
        check("first_pixel_latency", cyc, 4);
        wait_idle("full", 2000, cyc);
        check("full_frame_cycles", cyc, NPIX);
        check("full_accepted", accepted, NPIX);
        check("full_frame_flags", frame_flags, 1);
        check("full_sb_empty", sbq.size(), 0);
        check("flag_coincide", coincide, 0);
        check("full_flag_low_at_end", int'(bus.pixel_flag), 0);

        // Random backpressure.
        credit_viol = 0;
        stable_viol = 0;
        frame_flags = 0;
        pulse_start();
        cyc = 0;
        while (bus.busy && cyc < 5000) begin
            bus.pixel_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("rand_idle_in_time", int'(bus.busy), 0);
        check("rand_accepted", accepted, NPIX);
        check("rand_credit_viol", credit_viol, 0);
        check("rand_stable_viol", stable_viol, 0);
        check("rand_sb_empty", sbq.size(), 0);

        // Consumer stalled for 100 cycles after start.
        bus.pixel_ready = 1'b0;
        stable_viol = 0;
        pulse_start();
        repeat (100) tick();
        check("stall_reads_issued", issued, DEPTH);
        check("stall_pixel_flag", int'(bus.pixel_flag), 1);
        check("stall_pixel", int'(bus.pixel), 0);
        check("stall_pixel_x", int'(bus.pixel_x), 0);
        check("stall_pixel_y", int'(bus.pixel_y), 0);
        check("stall_stable_viol", stable_viol, 0);
        bus.pixel_ready = 1'b1;
        wait_idle("stall", 2000, cyc);
        check("stall_accepted", accepted, NPIX);

        // Second start mid-frame is ignored.
        frame_flags = 0;
        pulse_start();
        repeat (30) tick();
        pulse_start();
        wait_idle("restart", 2000, cyc);
        check("restart_frame_flags", frame_flags, 1);
        check("restart_accepted", accepted, NPIX);
        repeat (5) tick();
        check("restart_no_second_frame", int'(bus.busy), 0);

        // Reset mid-frame, stale memory data must be dropped.
        pulse_start();
        cyc = 0;
        while (accepted < 50 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("reached_pixel_50", int'(accepted >= 50), 1);
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stale_data_ignored", int'(bus.pixel_flag), 0);
            tick();
        end
        frame_flags = 0;
        pulse_start();
        cyc = 0;
        while (!bus.pixel_flag && cyc < 20) begin
            tick();
            cyc++;
        end
        check("post_reset_first_x", int'(bus.pixel_x), 0);
        check("post_reset_first_y", int'(bus.pixel_y), 0);
        check("post_reset_first_pixel", int'(bus.pixel), 0);
        wait_idle("post_reset", 2000, cyc);
        check("post_reset_accepted", accepted, NPIX);
        check("post_reset_frame_flags", frame_flags, 1);

        // 4x2 frame driven from a table of stalls and expected coordinates.
        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{2, 1, 0, 1};
        tbl[2] = '{0, 2, 0, 2};
        tbl[3] = '{1, 3, 0, 3};
        tbl[4] = '{0, 0, 1, 4};
        tbl[5] = '{3, 1, 1, 5};
        tbl[6] = '{0, 2, 1, 6};
        tbl[7] = '{0, 3, 1, 7};
        bus_s.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        for (int i = 0; i < HS*VS; i++) begin
            bus_s.pixel_ready = 1'b0;
            repeat (tbl[i].stall) tick();
            bus_s.pixel_ready = 1'b1;
            cyc = 0;
            while (!bus_s.pixel_flag && cyc < 20) begin
                tick();
                cyc++;
            end
            check("small_flag", int'(bus_s.pixel_flag), 1);
            check("small_x", int'(bus_s.pixel_x), tbl[i].x);
            check("small_y", int'(bus_s.pixel_y), tbl[i].y);
            check("small_pixel", int'(bus_s.pixel), tbl[i].pix);
            tick();
        end
        bus_s.pixel_ready = 1'b0;
        check("small_busy_after_last", int'(bus_s.busy), 0);
        check("small_flag_after_last", int'(bus_s.pixel_flag), 0);
        check("small_x_wrapped", int'(bus_s.pixel_x), 0);
        check("small_y_wrapped", int'(bus_s.pixel_y), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
